// File: rtl/zle_dec.sv
// Zero-length-encoding decoder: literal tokens pass straight through, run tokens
// expand into n+1 zero words. Mealy handshakes, zero latency on both streams.
module zle_dec #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_v,
  output logic          i_b,
  input  logic [W:0]    i_d,
  output logic          o_v,
  input  logic          o_b,
  output logic [W-1:0]  o_d,
  output logic [1:0]    stateo,
  output logic          fireo,
  output logic [CW-1:0] runo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    i_b     = 1'b1;
    o_v     = 1'b0;
    fireo   = 1'b0;
    o_d     = '0;
    state_d = state_q;
    cnt_d   = cnt_q;
    // Outputs are held quiet while reset is low, even though they are combinational.
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (i_v && !o_b) begin
            i_b   = 1'b0;
            o_v   = 1'b1;
            fireo = 1'b1;
            if (!i_d[W]) begin
              o_d = i_d[W-1:0];
            end else if (i_d[CW-1:0] != '0) begin
              // First zero goes out now; cnt counts the zeros still owed.
              cnt_d   = i_d[CW-1:0];
              state_d = RUN;
            end
          end
        end
        RUN: begin
          if (!o_b) begin
            o_v   = 1'b1;
            fireo = 1'b1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_d = IDLE;
          end
        end
        default: begin
          i_b     = 1'bx;
          o_v     = 1'bx;
          fireo   = 1'bx;
          state_d = state_t'(2'bxx);
        end
      endcase
    end
  end

  assign stateo = state_q;
  assign runo   = cnt_q;

endmodule
